// File: rtl/output_ctrl_pkg.sv
// Shared constants, header field positions and FSM state encoding for the
// port read controller.
package output_ctrl_pkg;

    localparam int BLK_WORDS      = 16;
    localparam int HDR_BYTES      = 4;
    localparam int BLK_ADDR_WIDTH = 12;
    localparam int DATA_WIDTH     = 32;
    localparam int DA_WIDTH       = 4;
    localparam int PRORITY_WIDTH  = 3;
    localparam int LEN_WIDTH      = 10;
    localparam int WORD_IDX_WIDTH = 4;
    localparam int BLK_CNT_WIDTH  = 5;

    localparam int HDR_DA_LSB  = 0;
    localparam int HDR_PRI_LSB = 4;
    localparam int HDR_LEN_LSB = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR_REQ,
        S_ADDR_WAIT,
        S_HDR_RD,
        S_HDR_WAIT,
        S_BLK_RD,
        S_NEXT,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/output_ctrl_pkt_len_calc.sv
// Payload length to block count and word count of the final block.
// Kept as its own module so the write side sizes packets identically.
module pkt_len_calc
    import output_ctrl_pkg::*;
(
    input  logic [LEN_WIDTH-1:0]     len,
    output logic [BLK_CNT_WIDTH-1:0] need_blks,
    output logic [BLK_CNT_WIDTH-1:0] last_words
);

    logic [10:0] tot;

    assign tot       = {1'b0, len} + 11'(HDR_BYTES);
    assign need_blks = tot[10:6] + {4'b0, |tot[5:0]};
    // A byte count that fills the last block exactly still needs all 16 words.
    assign last_words = (tot[5:0] == 6'd0) ? 5'(BLK_WORDS)
                                           : ({1'b0, tot[5:2]} + {4'b0, |tot[1:0]});

endmodule

// File: rtl/output_ctrl.sv
// Read-side port controller: fetches block addresses for one packet, streams
// it out of the shared SRAM as sop/vld/eop beats and releases each block.
module output_ctrl
    import output_ctrl_pkg::*;
(
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_pkt_start,
    output logic                      o_blk_req,
    input  logic                      i_blk_addr_vld,
    input  logic [BLK_ADDR_WIDTH-1:0] i_blk_addr,
    output logic                      o_sram_rd_en,
    output logic [BLK_ADDR_WIDTH-1:0] o_sram_rd_addr,
    input  logic [DATA_WIDTH-1:0]     i_sram_rd_data,
    output logic                      o_sop,
    output logic                      o_vld,
    output logic [DATA_WIDTH-1:0]     o_data,
    output logic                      o_eop,
    output logic [DA_WIDTH-1:0]       o_da,
    output logic [PRORITY_WIDTH-1:0]  o_prority,
    output logic                      o_free_addr_vld,
    output logic [BLK_ADDR_WIDTH-1:0] o_free_addr,
    output logic                      o_busy,
    output logic                      o_pkt_done,
    output state_t                    o_dbg_state
);

    state_t                    state_q, state_d;
    logic [BLK_ADDR_WIDTH-1:0] base_q, base_d;
    logic [WORD_IDX_WIDTH-1:0] word_idx_q, word_idx_d;
    logic [BLK_CNT_WIDTH-1:0]  blk_left_q, blk_left_d;
    logic [BLK_CNT_WIDTH-1:0]  last_words_q, last_words_d;
    logic                      first_q, first_d;
    logic                      rd_pend_q, pend_sop_q, pend_eop_q;

    logic                      rd_sop, rd_eop, hdr_eop, hdr_load, free_now;
    logic [BLK_CNT_WIDTH-1:0]  need_blks, last_words, lim_m1;

    pkt_len_calc u_len_calc (
        .len        (i_sram_rd_data[HDR_LEN_LSB +: LEN_WIDTH]),
        .need_blks  (need_blks),
        .last_words (last_words)
    );

    assign lim_m1 = ((blk_left_q == 5'd1) ? last_words_q : 5'(BLK_WORDS)) - 5'd1;

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        word_idx_d   = word_idx_q;
        blk_left_d   = blk_left_q;
        last_words_d = last_words_q;
        first_d      = first_q;
        o_blk_req    = 1'b0;
        o_sram_rd_en = 1'b0;
        rd_sop       = 1'b0;
        rd_eop       = 1'b0;
        hdr_eop      = 1'b0;
        hdr_load     = 1'b0;
        free_now     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_pkt_start) begin
                    first_d = 1'b1;
                    state_d = S_ADDR_REQ;
                end
            end
            S_ADDR_REQ: begin
                o_blk_req = 1'b1;
                state_d   = S_ADDR_WAIT;
            end
            S_ADDR_WAIT: begin
                if (i_blk_addr_vld) begin
                    base_d     = i_blk_addr;
                    word_idx_d = '0;
                    state_d    = first_q ? S_HDR_RD : S_BLK_RD;
                end
            end
            S_HDR_RD: begin
                o_sram_rd_en = 1'b1;
                rd_sop       = 1'b1;
                first_d      = 1'b0;
                state_d      = S_HDR_WAIT;
            end
            S_HDR_WAIT: begin
                // The header word is on i_sram_rd_data this cycle.
                hdr_load     = 1'b1;
                blk_left_d   = need_blks;
                last_words_d = last_words;
                if (need_blks == 5'd1 && last_words == 5'd1) begin
                    free_now   = 1'b1;
                    hdr_eop    = 1'b1;
                    blk_left_d = '0;
                    state_d    = S_NEXT;
                end else begin
                    word_idx_d = 4'd1;
                    state_d    = S_BLK_RD;
                end
            end
            S_BLK_RD: begin
                o_sram_rd_en = 1'b1;
                if ({1'b0, word_idx_q} == lim_m1) begin
                    free_now   = 1'b1;
                    rd_eop     = (blk_left_q == 5'd1);
                    blk_left_d = blk_left_q - 5'd1;
                    state_d    = S_NEXT;
                end else begin
                    word_idx_d = word_idx_q + 4'd1;
                end
            end
            S_NEXT: begin
                state_d = (blk_left_q == '0) ? S_DRAIN : S_ADDR_REQ;
            end
            S_DRAIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Base addresses are block aligned, so the word index simply fills the low bits.
    assign o_sram_rd_addr  = o_sram_rd_en ? {base_q[BLK_ADDR_WIDTH-1:WORD_IDX_WIDTH], word_idx_q} : '0;
    assign o_free_addr_vld = free_now;
    assign o_free_addr     = free_now ? base_q : '0;
    assign o_busy          = (state_q != S_IDLE);
    assign o_dbg_state     = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            word_idx_q   <= '0;
            blk_left_q   <= '0;
            last_words_q <= '0;
            first_q      <= 1'b0;
            rd_pend_q    <= 1'b0;
            pend_sop_q   <= 1'b0;
            pend_eop_q   <= 1'b0;
            o_vld        <= 1'b0;
            o_sop        <= 1'b0;
            o_eop        <= 1'b0;
            o_pkt_done   <= 1'b0;
            o_data       <= '0;
            o_da         <= '0;
            o_prority    <= '0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            word_idx_q   <= word_idx_d;
            blk_left_q   <= blk_left_d;
            last_words_q <= last_words_d;
            first_q      <= first_d;
            rd_pend_q    <= o_sram_rd_en;
            pend_sop_q   <= rd_sop;
            pend_eop_q   <= rd_eop;
            o_vld        <= rd_pend_q;
            o_sop        <= pend_sop_q;
            o_eop        <= pend_eop_q | hdr_eop;
            o_pkt_done   <= pend_eop_q | hdr_eop;
            o_data       <= rd_pend_q ? i_sram_rd_data : '0;
            if (hdr_load) begin
                o_da      <= i_sram_rd_data[HDR_DA_LSB +: DA_WIDTH];
                o_prority <= i_sram_rd_data[HDR_PRI_LSB +: PRORITY_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_output_ctrl.sv
// Self-checking bench for output_ctrl: SRAM and block-address models, a
// reference stream built from packet length arithmetic, and a scoreboard.
module tb_output_ctrl;
    import output_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        pkt_start;
    logic        blk_req;
    logic        blk_addr_vld;
    logic [11:0] blk_addr;
    logic        sram_rd_en;
    logic [11:0] sram_rd_addr;
    logic [31:0] sram_rd_data;
    logic        sop, vld, eop, busy, pkt_done;
    logic [31:0] data;
    logic [3:0]  da;
    logic [2:0]  pri;
    logic        free_vld;
    logic [11:0] free_addr;
    state_t      dbg_state;

    logic [31:0] mem [0:4095];
    logic [34:0] exp_q[$];
    logic [11:0] exp_free_q[$];
    logic [11:0] exp_rd_q[$];
    logic [11:0] blk_q[$];
    logic [11:0] bases[$];

    int n_checks = 0;
    int n_fail = 0;
    int blk_req_cnt = 0;
    int beat_cnt = 0;
    int exp_nblk = 0;
    int addr_delay = 0;
    int stray_cnt = 0;

    output_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_pkt_start     (pkt_start),
        .o_blk_req       (blk_req),
        .i_blk_addr_vld  (blk_addr_vld),
        .i_blk_addr      (blk_addr),
        .o_sram_rd_en    (sram_rd_en),
        .o_sram_rd_addr  (sram_rd_addr),
        .i_sram_rd_data  (sram_rd_data),
        .o_sop           (sop),
        .o_vld           (vld),
        .o_data          (data),
        .o_eop           (eop),
        .o_da            (da),
        .o_prority       (pri),
        .o_free_addr_vld (free_vld),
        .o_free_addr     (free_addr),
        .o_busy          (busy),
        .o_pkt_done      (pkt_done),
        .o_dbg_state     (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] all_outputs();
        return 64'({blk_req, sram_rd_en, sram_rd_addr, sop, vld, eop, da, pri,
                    free_vld, free_addr, busy, pkt_done}) ^ 64'(data);
    endfunction

    // SRAM model: one cycle read latency
    always @(posedge clk) begin
        if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
    end

    // Block-address queue model, plus optional stray valid pulses
    initial begin
        blk_addr_vld = 1'b0;
        blk_addr = '0;
        forever begin
            @(negedge clk);
            if (blk_req && rst_n) begin
                blk_req_cnt++;
                repeat (addr_delay + 1) @(negedge clk);
                if (blk_q.size() == 0) begin
                    check("extra_blk_req", 64'(blk_q.size()), 64'd1);
                end else begin
                    blk_addr = blk_q.pop_front();
                    blk_addr_vld = 1'b1;
                    @(negedge clk);
                    blk_addr_vld = 1'b0;
                end
            end else if (stray_cnt > 0) begin
                stray_cnt--;
                blk_addr = 12'hFF0;
                blk_addr_vld = 1'b1;
                @(negedge clk);
                blk_addr_vld = 1'b0;
            end
        end
    end

    // Scoreboard: beats, SRAM read addresses and block releases
    initial begin
        forever begin
            @(negedge clk);
            if (vld) begin
                beat_cnt++;
                if (exp_q.size() == 0) check("extra_beat", 64'(exp_q.size()), 64'd1);
                else check("beat", 64'({sop, eop, pkt_done, data}), 64'(exp_q.pop_front()));
            end else if (sop || eop || pkt_done) begin
                check("flags_without_vld", 64'({sop, eop, pkt_done}), 64'd0);
            end
            if (sram_rd_en) begin
                if (exp_rd_q.size() == 0) check("extra_rd", 64'(exp_rd_q.size()), 64'd1);
                else check("rd_addr", 64'(sram_rd_addr), 64'(exp_rd_q.pop_front()));
            end
            if (free_vld) begin
                if (exp_free_q.size() == 0) check("extra_free", 64'(exp_free_q.size()), 64'd1);
                else check("free_addr", 64'(free_addr), 64'(exp_free_q.pop_front()));
            end
        end
    end

    function automatic int nblk_of(input int len);
        return (len + HDR_BYTES + 63) / 64;
    endfunction

    task automatic pick_bases(input int n);
        int start;
        start = $urandom_range(0, 255);
        bases.delete();
        for (int k = 0; k < n; k++) bases.push_back(12'(((start + k * 37) % 256) * 16));
    endtask

    // Reference model: a packet of tot bytes is ceil(tot/4) words laid out
    // 16 words per block in the order the block addresses are handed out.
    task automatic prepare(input int len, input int hda, input int hpri);
        int tot, words, nblk, cnt;
        logic first, last;
        exp_q.delete(); exp_free_q.delete(); exp_rd_q.delete(); blk_q.delete();
        blk_req_cnt = 0;
        beat_cnt = 0;
        foreach (bases[i]) begin
            for (int j = 0; j < 16; j++) mem[bases[i] + 12'(j)] = $urandom;
            blk_q.push_back(bases[i]);
        end
        mem[bases[0]] = {15'($urandom), 10'(len), 3'(hpri), 4'(hda)};
        tot = len + HDR_BYTES;
        words = (tot + 3) / 4;
        nblk = (tot + 63) / 64;
        exp_nblk = nblk;
        for (int i = 0; i < nblk; i++) begin
            cnt = words - 16 * i;
            if (cnt > 16) cnt = 16;
            for (int j = 0; j < cnt; j++) begin
                first = (i == 0 && j == 0);
                last = (i == nblk - 1 && j == cnt - 1);
                exp_q.push_back({first, last, last, mem[bases[i] + 12'(j)]});
                exp_rd_q.push_back(bases[i] + 12'(j));
            end
            exp_free_q.push_back(bases[i]);
        end
    endtask

    // Driver tasks
    task automatic pulse_start();
        @(negedge clk);
        pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
    endtask

    task automatic finish_pkt(input int hda, input int hpri, input int mid_start_at, input int stray_at);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            @(negedge clk);
            #1;
            pkt_start = (c == mid_start_at);
            if (c == stray_at) stray_cnt = 1;
            if (c > mid_start_at && exp_q.size() == 0 && exp_free_q.size() == 0 && !busy) done = 1'b1;
        end
        pkt_start = 1'b0;
        check("pkt_complete_in_time", 64'(done), 64'd1);
        repeat (4) @(negedge clk);
        check("blk_req_count", 64'(blk_req_cnt), 64'(exp_nblk));
        check("idle_after_pkt", 64'({busy, dbg_state}), 64'({1'b0, S_IDLE}));
        check("hdr_da", 64'(da), 64'(hda[3:0]));
        check("hdr_prority", 64'(pri), 64'(hpri[2:0]));
    endtask

    task automatic run_pkt(input int len, input int hda, input int hpri, input int mid_start_at, input int stray_at);
        prepare(len, hda, hpri);
        pulse_start();
        finish_pkt(hda, hpri, mid_start_at, stray_at);
    endtask

    initial begin
        int len_tbl[8] = '{59, 60, 61, 63, 64, 123, 124, 125};
        int len;
        bit reached;

        rst_n = 1'b0;
        pkt_start = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(S_IDLE));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        bases = '{12'h040};
        run_pkt(0, 9, 2, -1, -1);
        bases = '{12'h080};
        run_pkt(60, 1, 6, -1, -1);
        bases = '{12'h100, 12'h200};
        run_pkt(61, 14, 0, -1, -1);
        pick_bases(17);
        run_pkt(1023, 5, 3, -1, -1);

        // Slow address queue, stray address valid and a start while busy
        addr_delay = 10;
        pick_bases(nblk_of(200));
        run_pkt(200, 7, 4, 6, 3);
        addr_delay = 0;

        // Asynchronous reset in the middle of the first block
        pick_bases(nblk_of(800));
        prepare(800, 2, 1);
        pulse_start();
        reached = 1'b0;
        for (int c = 0; c < 200 && !reached; c++) begin
            @(negedge clk);
            #1;
            if (beat_cnt >= 5) reached = 1'b1;
        end
        check("reached_mid_block", 64'(reached), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", all_outputs(), 64'd0);
        check("async_reset_state", 64'(dbg_state), 64'(S_IDLE));
        exp_q.delete(); exp_free_q.delete(); exp_rd_q.delete(); blk_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        pick_bases(nblk_of(130));
        run_pkt(130, 11, 5, -1, -1);

        for (int t = 0; t < 8; t++) begin
            addr_delay = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) len = len_tbl[$urandom_range(0, 7)];
            else len = $urandom_range(0, 1023);
            pick_bases(nblk_of(len));
            run_pkt(len, $urandom_range(0, 15), $urandom_range(0, 7), -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
